// File: rtl/bg_scene_sequencer.sv
// Frame-rate background scene sequencer: steps background_state on vsync
// boundaries with pause/skip control; all outputs change only at frame edges.
module bg_scene_sequencer #(
  parameter int unsigned FRAMES_PER_SCENE = 120,
  parameter int unsigned NUM_SCENES       = 11,
  parameter logic [5:0]  INIT_COLOR       = 6'b110000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       pause,
  input  logic       skip,
  output logic [7:0] background_state,
  output logic [5:0] solid_color,
  output logic [9:0] moving_counter,
  output logic       frame_tick,
  output logic       scene_change,
  output logic       paused
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_e;

  localparam logic [9:0] LAST_FRAME = 10'(FRAMES_PER_SCENE - 1);
  localparam logic [7:0] LAST_SCENE = 8'(NUM_SCENES - 1);

  state_e     state_q, state_d;
  logic       vsync_q;
  logic [7:0] scene_q, scene_d;
  logic [5:0] color_q, color_d;
  logic [9:0] mcnt_q, mcnt_d;
  logic [9:0] fcnt_q, fcnt_d;
  logic       skip_pend_q, skip_pend_d;
  logic       tick_q, tick_d;
  logic       chg_q, chg_d;
  logic       rise, skip_eff, advance;

  // vsync_q resets high so a vsync held high through reset release is not an edge
  assign rise     = vsync & ~vsync_q;
  assign skip_eff = skip_pend_q | skip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vsync_q     <= 1'b1;
      scene_q     <= '0;
      color_q     <= INIT_COLOR;
      mcnt_q      <= '0;
      fcnt_q      <= '0;
      skip_pend_q <= 1'b0;
      tick_q      <= 1'b0;
      chg_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= vsync;
      scene_q     <= scene_d;
      color_q     <= color_d;
      mcnt_q      <= mcnt_d;
      fcnt_q      <= fcnt_d;
      skip_pend_q <= skip_pend_d;
      tick_q      <= tick_d;
      chg_q       <= chg_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    scene_d     = scene_q;
    color_d     = color_q;
    mcnt_d      = mcnt_q;
    fcnt_d      = fcnt_q;
    skip_pend_d = skip_eff;
    tick_d      = 1'b0;
    advance     = 1'b0;
    if (rise) begin
      tick_d = (state_q != IDLE);
      unique case (state_q)
        IDLE:   state_d = pause ? PAUSED : RUN;
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
            advance = skip_eff;
          end else if (fcnt_q == LAST_FRAME || skip_eff) begin
            advance = 1'b1;
          end else begin
            fcnt_d = fcnt_q + 10'd1;
            mcnt_d = mcnt_q + 10'd1;
          end
        end
        PAUSED: begin
          // Resuming frame is not counted; a pending skip still advances
          if (!pause) state_d = RUN;
          advance = skip_eff;
        end
        default: state_d = IDLE;
      endcase
    end
    if (advance) begin
      fcnt_d      = '0;
      mcnt_d      = '0;
      skip_pend_d = 1'b0;
      if (scene_q == LAST_SCENE) begin
        scene_d = '0;
        color_d = {color_q[3:0], color_q[5:4]};
      end else begin
        scene_d = scene_q + 8'd1;
      end
    end
    chg_d = advance;
  end

  always_comb begin
    background_state = scene_q;
    solid_color      = color_q;
    moving_counter   = mcnt_q;
    frame_tick       = tick_q;
    scene_change     = chg_q;
    paused           = (state_q == PAUSED);
  end

endmodule

// File: tb/tb_bg_scene_sequencer.sv
// Directed bench for bg_scene_sequencer: a short-scene instance (4 frames,
// 3 scenes) for sequencing/pause/skip/reset and a 1023-frame instance for range.
module tb_bg_scene_sequencer;

  logic clk = 1'b0;
  logic rst_n, rst2_n, vsync, pause, skip;
  logic [7:0] a_bs, b_bs;
  logic [5:0] a_col, b_col;
  logic [9:0] a_mc, b_mc;
  logic a_tick, a_chg, a_pau, b_tick, b_chg, b_pau;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bg_scene_sequencer #(.FRAMES_PER_SCENE(4), .NUM_SCENES(3), .INIT_COLOR(6'b110000)) u_a (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .pause(pause), .skip(skip),
    .background_state(a_bs), .solid_color(a_col), .moving_counter(a_mc),
    .frame_tick(a_tick), .scene_change(a_chg), .paused(a_pau));

  bg_scene_sequencer #(.FRAMES_PER_SCENE(1023), .NUM_SCENES(2), .INIT_COLOR(6'b110000)) u_b (
    .clk(clk), .rst_n(rst2_n), .vsync(vsync), .pause(pause), .skip(skip),
    .background_state(b_bs), .solid_color(b_col), .moving_counter(b_mc),
    .frame_tick(b_tick), .scene_change(b_chg), .paused(b_pau));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One frame: vsync low then high; returns at the negedge after the rising-edge sample
  task automatic frame(input bit sk);
    @(negedge clk) vsync = 1'b0;
    @(negedge clk);
    @(negedge clk) begin vsync = 1'b1; skip = sk; end
    @(negedge clk) skip = 1'b0;
  endtask

  task automatic skip_pulse();
    @(negedge clk) skip = 1'b1;
    @(negedge clk) skip = 1'b0;
  endtask

  task automatic chk_a(input string tag, input logic [7:0] bs, input logic [9:0] mc,
                       input logic chg, input logic pau);
    chk({tag, "_bs"}, a_bs, bs);
    chk({tag, "_mc"}, a_mc, mc);
    chk({tag, "_chg"}, a_chg, chg);
    chk({tag, "_pau"}, a_pau, pau);
  endtask

  initial begin
    logic [5:0] exp_col;
    rst_n = 1'b0; rst2_n = 1'b0; vsync = 1'b1; pause = 1'b0; skip = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_tick", a_tick, 1'b0);
    end
    chk_a("rst", 8'd0, 10'd0, 1'b0, 1'b0);
    chk("rst_col", a_col, 6'b110000);

    // First rise: IDLE -> RUN, no tick, nothing counted
    frame(1'b0);
    chk("first_tick", a_tick, 1'b0);
    chk_a("first", 8'd0, 10'd0, 1'b0, 1'b0);

    // Auto sequencing over 24 counted frames
    for (int n = 1; n <= 24; n++) begin
      frame(1'b0);
      chk("auto_tick", a_tick, 1'b1);
      chk_a("auto", 8'((n / 4) % 3), 10'(n % 4), (n % 4) == 0, 1'b0);
      case (n / 12)
        0:       exp_col = 6'b110000;
        1:       exp_col = 6'b000011;
        default: exp_col = 6'b001100;
      endcase
      chk("auto_col", a_col, exp_col);
    end
    @(negedge clk);
    chk("tick_low", a_tick, 1'b0);

    // Pause at count 2
    frame(1'b0); frame(1'b0);
    chk_a("pre_pause", 8'd0, 10'd2, 1'b0, 1'b0);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      frame(1'b0);
      chk("pause_tick", a_tick, 1'b1);
      chk_a("pause", 8'd0, 10'd2, 1'b0, 1'b1);
    end
    pause = 1'b0;
    frame(1'b0);
    chk_a("resume", 8'd0, 10'd2, 1'b0, 1'b0);
    frame(1'b0);
    chk_a("resume2", 8'd0, 10'd3, 1'b0, 1'b0);
    frame(1'b0);
    chk_a("resume_adv", 8'd1, 10'd0, 1'b1, 1'b0);

    // Mid-frame skip at count 1
    frame(1'b0);
    chk_a("skip_pre", 8'd1, 10'd1, 1'b0, 1'b0);
    skip_pulse();
    chk_a("skip_hold", 8'd1, 10'd1, 1'b0, 1'b0);
    frame(1'b0);
    chk_a("skip", 8'd2, 10'd0, 1'b1, 1'b0);

    // Three skips in one frame: one advance (wraps to 0, colour rotates)
    skip_pulse(); skip_pulse(); skip_pulse();
    frame(1'b0);
    chk_a("skip3", 8'd0, 10'd0, 1'b1, 1'b0);
    chk("skip3_col", a_col, 6'b110000);
    frame(1'b0);
    chk_a("skip3_after", 8'd0, 10'd1, 1'b0, 1'b0);

    // Skip coincident with the expiring rise
    frame(1'b0); frame(1'b0);
    chk_a("exp_pre", 8'd0, 10'd3, 1'b0, 1'b0);
    frame(1'b1);
    chk_a("exp_skip", 8'd1, 10'd0, 1'b1, 1'b0);
    frame(1'b0);
    chk_a("exp_after", 8'd1, 10'd1, 1'b0, 1'b0);

    // Skip while paused
    pause = 1'b1;
    frame(1'b0);
    chk_a("psk_pre", 8'd1, 10'd1, 1'b0, 1'b1);
    skip_pulse();
    frame(1'b0);
    chk_a("psk", 8'd2, 10'd0, 1'b1, 1'b1);
    frame(1'b0);
    chk_a("psk_hold", 8'd2, 10'd0, 1'b0, 1'b1);
    pause = 1'b0;
    frame(1'b0);
    chk_a("psk_resume", 8'd2, 10'd0, 1'b0, 1'b0);

    // Reset mid-operation with a pending skip
    frame(1'b0); frame(1'b0); frame(1'b0);
    chk_a("mrst_pre", 8'd2, 10'd3, 1'b0, 1'b0);
    skip_pulse();
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk_a("mrst", 8'd0, 10'd0, 1'b0, 1'b0);
    chk("mrst_col", a_col, 6'b110000);
    chk("mrst_tick", a_tick, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    frame(1'b0);
    chk("mrst_first_tick", a_tick, 1'b0);
    chk_a("mrst_first", 8'd0, 10'd0, 1'b0, 1'b0);
    frame(1'b0);
    chk_a("mrst_nostale", 8'd0, 10'd1, 1'b0, 1'b0);

    // Long scene: 1023 frames per scene
    @(negedge clk) rst2_n = 1'b1;
    frame(1'b0);
    chk("long_first_mc", b_mc, 10'd0);
    for (int i = 0; i < 1022; i++) frame(1'b0);
    chk("long_mc", b_mc, 10'd1022);
    chk("long_bs", b_bs, 8'd0);
    frame(1'b0);
    chk("long_adv_bs", b_bs, 8'd1);
    chk("long_adv_mc", b_mc, 10'd0);
    chk("long_adv_chg", b_chg, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
